// File: rtl/pv2_mem_arb.sv
// rtl/pv2_mem_arb.sv - two-port round-robin memory arbiter with in-order response routing
// Optional feature: define PV2_MEM_ARB_STATS_EN to enable grant/conflict counters.
module pv2_mem_arb #(
  parameter int unsigned p_depth   = 4,
  parameter int unsigned p_req_sz  = 67,
  parameter int unsigned p_resp_sz = 35
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_val,
  output logic                 req0_rdy,
  input  logic [p_req_sz-1:0]  req0_msg,
  input  logic                 req1_val,
  output logic                 req1_rdy,
  input  logic [p_req_sz-1:0]  req1_msg,
  output logic                 resp0_val,
  input  logic                 resp0_rdy,
  output logic [p_resp_sz-1:0] resp0_msg,
  output logic                 resp1_val,
  input  logic                 resp1_rdy,
  output logic [p_resp_sz-1:0] resp1_msg,
  output logic                 memreq_val,
  input  logic                 memreq_rdy,
  output logic [p_req_sz-1:0]  memreq_msg,
  input  logic                 memresp_val,
  output logic                 memresp_rdy,
  input  logic [p_resp_sz-1:0] memresp_msg,
  output logic                 err,
  output logic [31:0]          stat_grant0,
  output logic [31:0]          stat_grant1,
  output logic [31:0]          stat_conflict
);

  localparam int unsigned PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CW = PW + 1;

  // Routing FIFO holds the port id of every outstanding request, oldest at rd_ptr.
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [p_depth-1:0] route_q;
  logic               last_q, last_d;
  logic               err_q, err_d;

  logic fifo_full, fifo_empty, head, gnt0, gnt1, push, pop;

  // Grant selection, request handshakes and response steering (all combinational)
  always_comb begin
    fifo_full   = (count_q == CW'(p_depth));
    fifo_empty  = (count_q == '0);
    // last_q = 1 means port 1 won the previous transfer, so port 0 wins a tie
    gnt1        = req1_val & (~req0_val | ~last_q);
    gnt0        = req0_val & ~gnt1;
    memreq_val  = (req0_val | req1_val) & ~fifo_full;
    memreq_msg  = gnt1 ? req1_msg : req0_msg;
    req0_rdy    = memreq_rdy & ~fifo_full & gnt0;
    req1_rdy    = memreq_rdy & ~fifo_full & gnt1;
    push        = memreq_val & memreq_rdy;
    head        = route_q[rd_ptr_q];
    resp0_val   = memresp_val & ~fifo_empty & ~head;
    resp1_val   = memresp_val & ~fifo_empty & head;
    resp0_msg   = memresp_msg;
    resp1_msg   = memresp_msg;
    memresp_rdy = ~fifo_empty & (head ? resp1_rdy : resp0_rdy);
    pop         = memresp_val & memresp_rdy;
    err         = err_q;
  end

  // Next-state for pointers, occupancy, round-robin history and sticky error
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    last_d   = push ? gnt1 : last_q;
    // a response with nothing outstanding is dropped and flagged
    err_d    = err_q | (memresp_val & fifo_empty);
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  // Routing entry storage; contents are only read while count_q is non-zero
  always_ff @(posedge clk) begin
    if (push) route_q[wr_ptr_q] <= gnt1;
  end

`ifdef PV2_MEM_ARB_STATS_EN
  logic [31:0] grant0_q, grant1_q, conflict_q;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant0_q   <= '0;
      grant1_q   <= '0;
      conflict_q <= '0;
    end else begin
      if (push & gnt0 & ~&grant0_q) grant0_q <= grant0_q + 32'd1;
      if (push & gnt1 & ~&grant1_q) grant1_q <= grant1_q + 32'd1;
      if (req0_val & req1_val & ~&conflict_q) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign stat_grant0   = grant0_q;
  assign stat_grant1   = grant1_q;
  assign stat_conflict = conflict_q;
`else
  assign stat_grant0   = 32'd0;
  assign stat_grant1   = 32'd0;
  assign stat_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_pv2_mem_arb.sv
// tb/tb_pv2_mem_arb.sv - directed self-checking bench for pv2_mem_arb
module tb_pv2_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req0_rdy, req1_val, req1_rdy;
  logic [66:0] req0_msg, req1_msg, memreq_msg;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [34:0] resp0_msg, resp1_msg, memresp_msg;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic        err;
  logic [31:0] stat_grant0, stat_grant1, stat_conflict;

  int passed = 0;
  int total  = 0;

  localparam logic [31:0] MASK = 32'hC0DE_0000;

  pv2_mem_arb dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .err(err), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
    .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  function automatic logic [66:0] mk_req(input logic [31:0] addr, input logic [31:0] data);
    return {1'b0, addr, 2'b10, data};
  endfunction

  function automatic logic [34:0] mk_resp(input logic [31:0] data);
    return {1'b0, 2'b10, data};
  endfunction

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 0; resp1_rdy = 0; memreq_rdy = 0;
    memresp_val = 0; memresp_msg = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    tick();
    tick();
    reset = 1;
  endtask

  logic [31:0] exp0[$], exp1[$], mq[$];
  logic [31:0] d0, d1;
  int issued0, issued1, rcv0, rcv1, mwait, cyc;
  logic p0_pend, p1_pend, done;
  logic [31:0] exp_g0, exp_g1, exp_cf;

  initial begin
    // reset state, sampled while reset is still low
    reset = 0;
    idle_inputs();
    req0_val = 1; memresp_val = 1;
    tick();
    settle();
    chk("rst_memresp_rdy", memresp_rdy, 0);
    chk("rst_resp0_val", resp0_val, 0);
    chk("rst_resp1_val", resp1_val, 0);
    chk("rst_err", err, 0);
    chk("rst_stat_g0", stat_grant0, 0);
    chk("rst_stat_cf", stat_conflict, 0);
    tick();
    chk("rst_err_hold", err, 0);
    idle_inputs();
    reset = 1;
    tick();

    // single request on port 0, zero-delay memory
    req0_val = 1; req0_msg = mk_req(32'h1000, 32'h11); memreq_rdy = 1;
    settle();
    chk("t1_memreq_val", memreq_val, 1);
    chk("t1_memreq_addr", memreq_msg[65:34], 32'h1000);
    chk("t1_req0_rdy", req0_rdy, 1);
    chk("t1_req1_rdy", req1_rdy, 0);
    chk("t1_resp1_val_a", resp1_val, 0);
    tick();
    req0_val = 0;
    memresp_val = 1; memresp_msg = mk_resp(32'hAAAA); resp0_rdy = 1;
    settle();
    chk("t1_resp0_val", resp0_val, 1);
    chk("t1_resp0_msg", resp0_msg, mk_resp(32'hAAAA));
    chk("t1_resp1_val_b", resp1_val, 0);
    chk("t1_memresp_rdy", memresp_rdy, 1);
    tick();
    memresp_val = 0;
    settle();
    chk("t1_err", err, 0);

    // both ports valid every cycle: alternating grants starting at port 0
    do_reset();
    req0_val = 1; req1_val = 1; memreq_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    req0_msg = mk_req(32'h100, 32'h0); req1_msg = mk_req(32'h200, 32'h1);
    for (int i = 0; i < 6; i++) begin
      memresp_val = (i > 0);
      memresp_msg = mk_resp(32'h100 + i);
      settle();
      chk("t2_req0_rdy", req0_rdy, (i % 2) == 0);
      chk("t2_req1_rdy", req1_rdy, (i % 2) == 1);
      chk("t2_memreq_data", memreq_msg[31:0], i % 2);
      if (i > 0) begin
        chk("t2_resp0_val", resp0_val, ((i - 1) % 2) == 0);
        chk("t2_resp1_val", resp1_val, ((i - 1) % 2) == 1);
      end
      tick();
    end
    req0_val = 0; req1_val = 0; memresp_val = 1;
    settle();
    chk("t2_drain_resp1", resp1_val, 1);
    tick();
    memresp_val = 0;
    settle();
`ifdef PV2_MEM_ARB_STATS_EN
    exp_g0 = 3; exp_g1 = 3; exp_cf = 6;
`else
    exp_g0 = 0; exp_g1 = 0; exp_cf = 0;
`endif
    chk("t2_stat_g0", stat_grant0, exp_g0);
    chk("t2_stat_g1", stat_grant1, exp_g1);
    chk("t2_stat_cf", stat_conflict, exp_cf);
    chk("t2_err", err, 0);

    // FIFO full: exactly p_depth transfers, then blocked until a pop
    do_reset();
    req0_val = 1; req0_msg = mk_req(32'h300, 32'h3); memreq_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_fill_rdy", req0_rdy, 1);
      tick();
    end
    settle();
    chk("t3_full_rdy", req0_rdy, 0);
    chk("t3_full_val", memreq_val, 0);
    tick();
    tick();
    chk("t3_full_val_hold", memreq_val, 0);
    memresp_val = 1; memresp_msg = mk_resp(32'h33); resp0_rdy = 1;
    settle();
    chk("t3_pop_rdy", memresp_rdy, 1);
    chk("t3_pop_resp0", resp0_val, 1);
    chk("t3_pop_no_push", memreq_val, 0);
    tick();
    memresp_val = 0;
    settle();
    chk("t3_after_pop_val", memreq_val, 1);
    chk("t3_after_pop_rdy", req0_rdy, 1);

    // grants 0,1,1 with port 1 stalling its response
    do_reset();
    memreq_rdy = 1;
    req0_val = 1; req0_msg = mk_req(32'h400, 32'h40);
    tick();
    req0_val = 0; req1_val = 1; req1_msg = mk_req(32'h500, 32'h50);
    tick();
    req1_msg = mk_req(32'h504, 32'h51);
    tick();
    req1_val = 0;
    memresp_val = 1; memresp_msg = mk_resp(32'hD0); resp0_rdy = 1; resp1_rdy = 0;
    settle();
    chk("t4_r0_val", resp0_val, 1);
    chk("t4_r0_msg", resp0_msg, mk_resp(32'hD0));
    chk("t4_r0_r1val", resp1_val, 0);
    tick();
    memresp_msg = mk_resp(32'hD1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t4_stall_r1val", resp1_val, 1);
      chk("t4_stall_r0val", resp0_val, 0);
      chk("t4_stall_rdy", memresp_rdy, 0);
      tick();
    end
    resp1_rdy = 1;
    settle();
    chk("t4_rel_rdy", memresp_rdy, 1);
    chk("t4_rel_msg", resp1_msg, mk_resp(32'hD1));
    tick();
    memresp_msg = mk_resp(32'hD2);
    settle();
    chk("t4_r2_val", resp1_val, 1);
    chk("t4_r2_msg", resp1_msg, mk_resp(32'hD2));
    tick();
    memresp_val = 0;
    settle();
    chk("t4_err", err, 0);
    chk("t4_empty_rdy", memresp_rdy, 0);

    // spurious response sets sticky err; reset clears it
    do_reset();
    memresp_val = 1; memresp_msg = mk_resp(32'hEE); resp0_rdy = 1; resp1_rdy = 1;
    settle();
    chk("t5_spur_rdy", memresp_rdy, 0);
    chk("t5_spur_r0", resp0_val, 0);
    chk("t5_spur_r1", resp1_val, 0);
    tick();
    memresp_val = 0;
    settle();
    chk("t5_err_set", err, 1);
    tick();
    tick();
    chk("t5_err_sticky", err, 1);
    reset = 0;
    tick();
    reset = 1;
    settle();
    chk("t5_err_clr", err, 0);
    chk("t5_cnt_clr", stat_grant0, 0);

    // reset with a request outstanding: its late response is an error
    memreq_rdy = 1; req0_val = 1; req0_msg = mk_req(32'h600, 32'h60);
    tick();
    req0_val = 0;
    reset = 0;
    tick();
    reset = 1;
    memresp_val = 1;
    settle();
    chk("t6_orphan_rdy", memresp_rdy, 0);
    tick();
    memresp_val = 0;
    settle();
    chk("t6_orphan_err", err, 1);

    // randomly interleaved traffic with a delayed in-order memory
    do_reset();
    issued0 = 0; issued1 = 0; rcv0 = 0; rcv1 = 0; mwait = 0;
    p0_pend = 0; p1_pend = 0; done = 0; d0 = 0; d1 = 0;
    cyc = 0;
    while (!done && cyc < 600) begin
      if (!p0_pend && issued0 < 10 && $urandom_range(0, 1) == 1) begin
        p0_pend = 1;
        d0 = 32'hA000_0000 | issued0;
        req0_msg = mk_req(32'h2000 + issued0 * 4, d0);
      end
      if (!p1_pend && issued1 < 10 && $urandom_range(0, 1) == 1) begin
        p1_pend = 1;
        d1 = 32'hB000_0000 | issued1;
        req1_msg = mk_req(32'h3000 + issued1 * 4, d1);
      end
      req0_val = p0_pend;
      req1_val = p1_pend;
      memreq_rdy = ($urandom_range(0, 3) != 0);
      resp0_rdy = $urandom_range(0, 1);
      resp1_rdy = $urandom_range(0, 1);
      if (mq.size() > 0 && mwait == 0) begin
        memresp_val = 1;
        memresp_msg = mk_resp(mq[0] ^ MASK);
      end else begin
        memresp_val = 0;
        if (mwait > 0) mwait = mwait - 1;
      end
      settle();
      if (resp0_val && resp0_rdy) begin
        if (exp0.size() == 0) chk("rnd_resp0_unexpected", 1, 0);
        else begin
          chk("rnd_resp0_data", resp0_msg[31:0], exp0.pop_front());
          rcv0 = rcv0 + 1;
        end
      end
      if (resp1_val && resp1_rdy) begin
        if (exp1.size() == 0) chk("rnd_resp1_unexpected", 1, 0);
        else begin
          chk("rnd_resp1_data", resp1_msg[31:0], exp1.pop_front());
          rcv1 = rcv1 + 1;
        end
      end
      if (memresp_val && memresp_rdy) begin
        void'(mq.pop_front());
        mwait = $urandom_range(0, 3);
      end
      if (memreq_val && memreq_rdy) mq.push_back(memreq_msg[31:0]);
      if (req0_val && req0_rdy) begin
        exp0.push_back(d0 ^ MASK);
        issued0 = issued0 + 1;
        p0_pend = 0;
      end
      if (req1_val && req1_rdy) begin
        exp1.push_back(d1 ^ MASK);
        issued1 = issued1 + 1;
        p1_pend = 0;
      end
      tick();
      done = (issued0 == 10) && (issued1 == 10) && (mq.size() == 0) &&
             (exp0.size() == 0) && (exp1.size() == 0);
      cyc = cyc + 1;
    end
    idle_inputs();
    settle();
    chk("rnd_done", done, 1);
    chk("rnd_rcv0", rcv0, 10);
    chk("rnd_rcv1", rcv1, 10);
    chk("rnd_err", err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
